// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV window feeding a TX FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames, STATUS bit4 = 1).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0010,
    parameter logic [15:0] BAUD_DIV   = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    output logic        uart_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic        r_ovf;
    logic [15:0] r_baud, r_div, r_bcnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    state_t      r_state, w_next;
    logic        w_sel, w_wr_tx, w_wr_st, w_wr_bd, w_push_ok, w_pop;
    logic        w_full, w_empty, w_tick, w_busy, w_unused;
    logic [1:0]  w_off;
    logic [7:0]  w_head;

    assign w_sel     = MemBus_Address[31:4] == BASE_ADDR[31:4];
    assign w_off     = MemBus_Address[3:2];
    assign w_wr_tx   = MemWrite && w_sel && (w_off == 2'd0);
    assign w_wr_st   = MemWrite && w_sel && (w_off == 2'd1);
    assign w_wr_bd   = MemWrite && w_sel && (w_off == 2'd2);
    assign w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_empty   = r_cnt == '0;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_wr_tx && (!w_full || w_pop);
    assign w_head    = r_mem[r_rp];
    assign w_tick    = r_bcnt == (r_div - 16'd1);
    assign w_busy    = r_state != S_IDLE;
    assign w_unused  = &{1'b0, MemBus_Address[1:0], MemBus_Write_Data[31:16]};

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= MemBus_Write_Data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_baud <= BAUD_DIV;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop)     r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
            if (w_wr_tx && !w_push_ok)
                r_ovf <= 1'b1;
            else if (w_wr_st && MemBus_Write_Data[3])
                r_ovf <= 1'b0;
            if (w_wr_bd)
                r_baud <= (MemBus_Write_Data[15:0] == 16'd0) ? 16'd1 : MemBus_Write_Data[15:0];
        end
    end

    always_comb begin
        Device_Read_Data = '0;
        if (MemRead && w_sel) begin
            case (w_off)
                2'd1:    Device_Read_Data = {27'd0, PAR_EN, r_ovf, w_busy, w_full, w_empty};
                2'd2:    Device_Read_Data = {16'd0, r_baud};
                default: Device_Read_Data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next = S_START;
            S_START:  if (w_tick) w_next = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_tick) w_next = S_STOP;
`else
            S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_STOP;
`endif
            S_STOP:   if (w_tick) w_next = w_empty ? S_IDLE : S_START;
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_par <= 1'b0;
        else if (w_pop) r_par <= ^w_head;
    end
`endif

    always_comb begin
        w_pop    = 1'b0;
        uart_txd = 1'b1;
        case (r_state)
            S_IDLE:   w_pop = !w_empty;
            S_START:  uart_txd = 1'b0;
            S_DATA:   uart_txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: uart_txd = r_par;
`endif
            S_STOP:   w_pop = w_tick && !w_empty;
            default:  uart_txd = 1'b1;
        endcase
    end

    // Divisor is latched at each pop so BAUDDIV writes never disturb a frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= BAUD_DIV;
            r_bcnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (w_pop) begin
            r_shift <= w_head;
            r_div   <= r_baud;
            r_bcnt  <= '0;
            r_bit   <= '0;
        end else if (w_busy) begin
            if (w_tick) begin
                r_bcnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                end
            end else begin
                r_bcnt <= r_bcnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected frames are queued by stimulus, a line monitor decodes and checks them.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h4000_0010;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        txd;
    exp_t        exp_q[$];
    int          start_q[$];
    int          checks = 0, failures = 0, cyc = 0, frames_done = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  pat [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h7E, 8'h99};

    mmio_uart_tx #(.BASE_ADDR(BASE), .BAUD_DIV(16'd868), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemBus_Address(addr), .MemBus_Write_Data(wdata),
        .Device_Read_Data(rdata), .uart_txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] st(input logic [31:0] v);
        return v | 32'(PAR << 4);
    endfunction

    function automatic logic [11:0] frame(input logic [7:0] b);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PAR != 0) f[9] = ^b;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input int div);
        exp_t e;
        e.data = b;
        e.div  = div;
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRead = 1'b1;
        #1 d = rdata;
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frames_done", frames_done, n);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: cycle-exact comparison of every frame against the head of the scoreboard.
    initial begin : mon
        exp_t        e;
        logic [11:0] f, rx;
        int          bad;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame actual=start_bit required=idle_line");
                    while (txd === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    f = frame(e.data);
                    rx = '1; bad = 0;
                    start_q.push_back(cyc);
                    for (int b = 0; b < NB; b++) begin
                        for (int k = 0; k < e.div; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (k == e.div / 2) rx[b] = txd;
                            if (txd !== f[b]) bad++;
                        end
                    end
                    checks++;
                    if (bad != 0) begin
                        failures++;
                        $display("FAIL frame_%h actual_bits=%b required_bits=%b bad_cycles=%0d",
                                 e.data, rx, f, bad);
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d;
        int n, s0, f0;

        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        rdchk("rst_status", BASE + 4, st(32'h1));
        rdchk("rst_bauddiv", BASE + 8, 32'd868);
        rdchk("txdata_reads_zero", BASE, 32'd0);
        chk("idle_txd", 32'(txd), 32'd1);

        // Single A5 frame at D=4: latency, bit pattern, busy length
        wr(BASE + 8, 32'd4);
        rdchk("baud4", BASE + 8, 32'd4);
        push_exp(8'hA5, 4);
        wr(BASE, 32'hA5);
        chk("lat_txd_n", 32'(txd), 32'd1);
        rdchk("status_queued", BASE + 4, st(32'h0));
        @(negedge clk);
        chk("lat_txd_n1", 32'(txd), 32'd0);
        rdchk("status_busy", BASE + 4, st(32'h5));
        n = 0;
        rd(BASE + 4, d);
        while (d[2] && n < 200) begin
            @(negedge clk);
            n++;
            rd(BASE + 4, d);
        end
        chk("busy_cycles", n, 4 * NB);
        wait_frames(1, 50);

        // Nine back-to-back bytes at D=2: fills FIFO, no gaps, no overflow
        wr(BASE + 8, 32'd2);
        f0 = frames_done; s0 = start_q.size();
        for (int i = 0; i < 9; i++) push_exp(pat[i], 2);
        for (int i = 0; i < 9; i++) wr(BASE, 32'(pat[i]));
        rdchk("full_after9", BASE + 4, st(32'h6));
        wait_frames(f0 + 9, 9 * 2 * NB + 40);
        for (int i = 1; i < 9; i++)
            chk("b2b_gap", start_q[s0 + i] - start_q[s0 + i - 1], 2 * NB);
        rdchk("status_after_b2b", BASE + 4, st(32'h1));

        // Overflow at D=100, clear, then a mid-frame divisor change
        wr(BASE + 8, 32'd100);
        f0 = frames_done; s0 = start_q.size();
        push_exp(pat[0], 100);
        for (int i = 1; i < 9; i++) push_exp(pat[i], 50);
        for (int i = 0; i < 10; i++) wr(BASE, 32'(pat[i]));
        rdchk("ovf_set", BASE + 4, st(32'hE));
        wr(BASE + 4, 32'h8);
        rdchk("ovf_clr", BASE + 4, st(32'h6));
        wr(BASE + 8, 32'd50);
        rdchk("baud50", BASE + 8, 32'd50);
        rdchk("addr_lsb_ignored", BASE + 8 + 3, 32'd50);
        wr(BASE + 12, 32'hFFFF_FFFF);
        rdchk("rsvd_write_no_effect", BASE + 8, 32'd50);
        rdchk("rsvd_read", BASE + 12, 32'd0);
        wait_frames(f0 + 9, 100 * NB + 8 * 50 * NB + 100);
        chk("old_div_frame_len", start_q[s0 + 1] - start_q[s0], 100 * NB);
        chk("new_div_frame_len", start_q[s0 + 2] - start_q[s0 + 1], 50 * NB);
        rdchk("status_after_ovf", BASE + 4, st(32'h1));

        // Asynchronous reset in the middle of DATA
        mon_en = 1'b0;
        wr(BASE + 8, 32'd8);
        wr(BASE, 32'h00);
        repeat (12) @(negedge clk);
        chk("mid_data_txd", 32'(txd), 32'd0);
        #2 reset = 1'b1;
        #1 chk("async_rst_txd", 32'(txd), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rdchk("post_rst_status", BASE + 4, st(32'h1));
        rdchk("post_rst_baud", BASE + 8, 32'd868);
        rdchk("unselected_read", BASE + 16, 32'd0);
        addr = BASE + 8;
        #1 chk("no_memread_zero", rdata, 32'd0);
        addr = '0;
        chk("post_rst_txd", 32'(txd), 32'd1);
        mon_en = 1'b1;

        // Divisor 0 clamps to 1; 8'h07 frame (parity bit 1 when enabled)
        wr(BASE + 8, 32'd0);
        rdchk("baud_zero_as_one", BASE + 8, 32'd1);
        f0 = frames_done;
        push_exp(8'h07, 1);
        wr(BASE, 32'h07);
        wait_frames(f0 + 1, NB + 20);
        rdchk("final_status", BASE + 4, st(32'h1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data bus, downstream of the single-cycle CPU's memory port. It decodes `MemRead`/`MemWrite`/`MemBus_Address` and buffers bytes in a small FIFO. It serialises the bytes onto `uart_txd` as 8N1 frames and returns status and config words on `Device_Read_Data` within the same cycle.

## Interface
- `BASE_ADDR`, default 32'h4000_0010: base of the 3-word register window, word aligned.
- `BAUD_DIV`, default 16'd868: reset value of the divisor; clk cycles per bit (100 MHz / 115200).
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..64.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `MemRead`  in  1  CPU read strobe.
- `MemWrite`  in  1  CPU write strobe.
- `MemBus_Address`  in  32  byte address from the CPU ALU.
- `MemBus_Write_Data`  in  32  CPU store data.
- `Device_Read_Data`  out  32  combinational read data; 0 when not selected.
- `uart_txd`  out  1  serial output; idle high.

## Operation
- Select condition: `MemBus_Address[31:4]` == `BASE_ADDR[31:4]`. Offset = `MemBus_Address[3:2]`. Address bits [1:0] are ignored.
- Offset 0, TXDATA, write-only: a write pushes `MemBus_Write_Data[7:0]`. A read returns 0.
- Offset 1, STATUS: bit0 = empty, bit1 = full, bit2 = busy (FSM not IDLE), bit3 = overflow (sticky). Other bits read 0. A write with bit3 = 1 clears overflow. Other written bits are ignored.
- Offset 2, BAUDDIV: read/write, bits [15:0]. A written value of 0 is stored as 1. Bits [31:16] read 0.
- Offset 3 is reserved. It reads 0 and writes have no effect.
- `Device_Read_Data` = 0 unless `MemRead` is high and the select condition holds. Reads have no side effects.
- FIFO push rule: a push is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and overflow is set.
- FIFO pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1.
- FSM states are IDLE, START, DATA, STOP (plus PARITY when configured).
- IDLE: `uart_txd` = 1. If the FIFO is non-empty, pop the head into the shift register, latch BAUDDIV into the working divisor D, and go to START.
- START: `uart_txd` = 0 for D cycles, then go to DATA.
- DATA: send 8 bits LSB first, each for D cycles. A bit index of 0..7 drives the sequencing. After bit 7, go to STOP (or PARITY).
- STOP: `uart_txd` = 1 for D cycles. On the final cycle, if the FIFO is non-empty, pop the next byte, relatch D, and go directly to START. Otherwise go to IDLE.
- A BAUDDIV write mid-frame does not change the frame in progress. It applies from the next pop.

## Timing
- Reset values:
  - `uart_txd` = 1 and `Device_Read_Data` = 0 with bus idle.
  - FIFO is empty, overflow = 0, FSM = IDLE, BAUDDIV = `BAUD_DIV`.
- Reset clears everything immediately and asynchronously, including mid-frame. `uart_txd` returns high with no truncated-frame recovery.
- Writes take effect on the rising clk edge where `MemWrite` is high. A write at edge N makes empty = 0 visible after N.
- Start latency: with the FSM in IDLE, a TXDATA write at edge N gives a pop at edge N+1. `uart_txd` falls after N+1.
- Frame length is exactly 10·D cycles (11·D with parity).
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- busy is high from the pop edge until the edge that returns the FSM to IDLE.
- Simultaneous push while full and pop at the end of STOP: the push is accepted and the FIFO stays full.
- Simultaneous overflow-clear write and overflowing push cannot occur, because the bus carries one access per cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted after DATA. It drives the even parity bit (XOR of the 8 data bits) for D cycles.
  - The frame becomes 11·D cycles.
  - STATUS bit4 reads 1.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state; frame is 8N1, 10·D cycles.
  - STATUS bit4 reads 0.

## Test plan
- Reset, then read STATUS -> 32'h0000_0001. Read BAUDDIV -> 868. `uart_txd` = 1 throughout.
- BAUDDIV = 4, write 8'hA5 to TXDATA -> `uart_txd` falls 1 cycle later. The line reads bits 0,1,0,1,0,0,1,0,1,1 at 4 cycles each. busy returns to 0 after 40 cycles.
- BAUDDIV = 2, write 9 bytes back-to-back -> STATUS.full = 1 after the 9th write (one byte already in the shifter). All 9 frames are sent with no idle gap. overflow stays 0.
- BAUDDIV = 100, write 10 bytes -> the 10th is dropped and STATUS bit3 = 1. Writing 32'h8 to STATUS clears it.
- Assert reset mid-DATA -> `uart_txd` = 1 immediately and STATUS = 32'h1 after release. A read at offset 3 or an unselected address -> 0.
- With `UART_TX_PARITY_EN` and BAUDDIV = 1, send 8'h07 -> the parity bit is 1 and the frame is 11 cycles.
